// File: rtl/musa_ctrl_pkg.sv
// Shared MUSA controller definitions: opcodes, ALU functs, PC source codes, FSM states, instruction classes.
// Consumed by both the multi-cycle controller and its opcode decoder.
package musa_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001110;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JR   = 6'b010000;
  localparam logic [5:0] OP_JPC  = 6'b001001;
  localparam logic [5:0] OP_BRFL = 6'b010001;
  localparam logic [5:0] OP_CALL = 6'b000011;
  localparam logic [5:0] OP_RET  = 6'b000111;
  localparam logic [5:0] OP_NOP  = 6'b000001;
  localparam logic [5:0] OP_HALT = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REG = 2'b01;
  localparam logic [1:0] PC_REL = 2'b10;
  localparam logic [1:0] PC_STK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_HALT, CLS_ILL, CLS_R, CLS_IMM, CLS_LW, CLS_SW,
    CLS_JR, CLS_JPC, CLS_BRFL, CLS_CALL, CLS_RET
  } cls_e;

endpackage

// File: rtl/musa_ctrl_decode.sv
// Combinational opcode classifier: instruction class, illegal flag and the ALU funct implied by
// immediate/memory opcodes. No state, no handshake.
module musa_ctrl_decode
  import musa_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output cls_e                cls_o,
  output logic                illegal_o,
  output logic [FUNCT_W-1:0]  imm_funct_o
);

  always_comb begin
    cls_o       = CLS_ILL;
    imm_funct_o = '0;
    case (opcode_i)
      OPCODE_W'(OP_R):    cls_o = CLS_R;
      OPCODE_W'(OP_ADDI): begin cls_o = CLS_IMM; imm_funct_o = FUNCT_W'(FN_ADD); end
      OPCODE_W'(OP_SUBI): begin cls_o = CLS_IMM; imm_funct_o = FUNCT_W'(FN_SUB); end
      OPCODE_W'(OP_ANDI): begin cls_o = CLS_IMM; imm_funct_o = FUNCT_W'(FN_AND); end
      OPCODE_W'(OP_ORI):  begin cls_o = CLS_IMM; imm_funct_o = FUNCT_W'(FN_OR);  end
      OPCODE_W'(OP_LW):   begin cls_o = CLS_LW;  imm_funct_o = FUNCT_W'(FN_ADD); end
      OPCODE_W'(OP_SW):   begin cls_o = CLS_SW;  imm_funct_o = FUNCT_W'(FN_ADD); end
      OPCODE_W'(OP_JR):   cls_o = CLS_JR;
      OPCODE_W'(OP_JPC):  cls_o = CLS_JPC;
      OPCODE_W'(OP_BRFL): cls_o = CLS_BRFL;
      OPCODE_W'(OP_CALL): cls_o = CLS_CALL;
      OPCODE_W'(OP_RET):  cls_o = CLS_RET;
      OPCODE_W'(OP_NOP):  cls_o = CLS_NOP;
      OPCODE_W'(OP_HALT): cls_o = CLS_HALT;
      default: ;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/musa_multicycle_ctrl.sv
// MUSA multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, 2..5 cycles per instruction plus memory waits.
// Stalls in FETCH/MEM until the ack arrives; traps with bus_err after MEM_TIMEOUT unacked cycles.
module musa_multicycle_ctrl
  import musa_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int FUNCT_W     = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode_in,
  input  logic [FUNCT_W-1:0]  funct_in,
  input  logic                flag_in,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                alu_src_imm,
  output logic [FUNCT_W-1:0]  alu_funct,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                mem_to_reg,
  output logic                push,
  output logic                pop,
  output logic                halted,
  output logic                illegal,
  output logic                bus_err
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic [FUNCT_W-1:0]  funct_q;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                halted_q, halted_d, illegal_q, illegal_d, bus_err_q, bus_err_d;

  cls_e                cls;
  logic                dec_illegal;
  logic [FUNCT_W-1:0]  imm_funct;
  logic                ack, timeout;

  musa_ctrl_decode #(.OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W)) u_decode (
    .opcode_i    (opcode_q),
    .cls_o       (cls),
    .illegal_o   (dec_illegal),
    .imm_funct_o (imm_funct)
  );

  // The cycle that would complete the MEM_TIMEOUT-th unacked wait traps; an ack in that cycle wins.
  assign ack     = (state_q == ST_FETCH) ? imem_ack : dmem_ack;
  assign timeout = (MEM_TIMEOUT != 0) && !ack && (int'(wait_q) + 1 >= MEM_TIMEOUT);

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (ack) state_d = ST_DECODE;
        else if (timeout) begin state_d = ST_TRAP; bus_err_d = 1'b1; end
        else if (MEM_TIMEOUT != 0) wait_d = wait_q + 1'b1;
      end
      ST_DECODE: begin
        if (dec_illegal) begin state_d = ST_TRAP; illegal_d = 1'b1; end
        else if (cls == CLS_NOP) state_d = ST_FETCH;
        else if (cls == CLS_HALT) begin state_d = ST_HALT; halted_d = 1'b1; end
        else state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CLS_R, CLS_IMM: state_d = ST_WB;
          CLS_LW, CLS_SW: state_d = ST_MEM;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (ack) state_d = (cls == CLS_LW) ? ST_WB : ST_FETCH;
        else if (timeout) begin state_d = ST_TRAP; bus_err_d = 1'b1; end
        else if (MEM_TIMEOUT != 0) wait_d = wait_q + 1'b1;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      funct_q   <= '0;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      if (state_q == ST_FETCH && imem_ack) begin
        opcode_q <= opcode_in;
        funct_q  <= funct_in;
      end
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;
    alu_funct   = '0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    mem_to_reg  = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin ir_load = 1'b1; pc_write = 1'b1; end
      end
      ST_EXEC: begin
        case (cls)
          CLS_R:                  alu_funct = funct_q;
          CLS_IMM, CLS_LW, CLS_SW: begin alu_src_imm = 1'b1; alu_funct = imm_funct; end
          CLS_JR:   begin pc_write = 1'b1; pc_src = PC_REG; end
          CLS_JPC:  begin pc_write = 1'b1; pc_src = PC_REL; end
          CLS_BRFL: begin pc_write = flag_in; pc_src = PC_REL; end
          CLS_CALL: begin push = 1'b1; pc_write = 1'b1; pc_src = PC_REL; end
          CLS_RET:  begin pop = 1'b1; pc_write = 1'b1; pc_src = PC_STK; end
          default: ;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_SW);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == CLS_LW);
      end
      default: ;
    endcase
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_musa_multicycle_ctrl.sv
// Randomized bench: each instruction is expanded into a per-cycle list of stimulus and expected
// outputs from the instruction-class timing rules, then replayed against the controller.
module tb_musa_multicycle_ctrl;

  localparam int TO   = 15;
  localparam int HOLD = 20;

  logic       clk, rst_n;
  logic [5:0] opcode_in, funct_in;
  logic       flag_in, imem_ack, dmem_ack;
  logic       imem_req, ir_load, pc_write, reg_write, alu_src_imm;
  logic [1:0] pc_src;
  logic [5:0] alu_funct;
  logic       dmem_req, dmem_we, mem_to_reg, push, pop, halted, illegal, bus_err;

  musa_multicycle_ctrl #(.OPCODE_W(6), .FUNCT_W(6), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_in(opcode_in), .funct_in(funct_in), .flag_in(flag_in),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .alu_src_imm(alu_src_imm),
    .alu_funct(alu_funct), .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_to_reg(mem_to_reg),
    .push(push), .pop(pop), .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, ir_load, pc_write, pc_src, reg_write, alu_src_imm, alu_funct,
  //  dmem_req, dmem_we, mem_to_reg, push, pop, halted, illegal, bus_err}
  logic [20:0] act;
  assign act = {imem_req, ir_load, pc_write, pc_src, reg_write, alu_src_imm, alu_funct,
                dmem_req, dmem_we, mem_to_reg, push, pop, halted, illegal, bus_err};

  typedef struct {
    logic        ia, da, fl;
    logic [5:0]  op, fn;
    logic [20:0] exp;
  } step_t;

  step_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic [20:0] ov(input logic ireq, irl, pcw, input logic [1:0] pcs,
                                     input logic rw, imm, input logic [5:0] fn,
                                     input logic dreq, dwe, m2r, psh, pp, hlt, ill, berr);
    return {ireq, irl, pcw, pcs, rw, imm, fn, dreq, dwe, m2r, psh, pp, hlt, ill, berr};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001000, 6'b001110, 6'b001100, 6'b001101, 6'b100011, 6'b101011,
      6'b010000, 6'b001001, 6'b010001, 6'b000011, 6'b000111, 6'b000001, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic add(input logic ia, da, fl, input logic [5:0] op, fn, input logic [20:0] exp);
    step_t s;
    s.ia = ia; s.da = da; s.fl = fl; s.op = op; s.fn = fn; s.exp = exp;
    q.push_back(s);
  endtask

  task automatic add_hold(input logic [20:0] flags);
    for (int k = 0; k < HOLD; k++) add(rb(), rb(), rb(), r6(), r6(), flags);
  endtask

  // Expand one instruction into its expected cycles; term=1 when it ends in HALT or TRAP.
  task automatic gen(input logic [5:0] op, fn, input int iw, dw, input logic fl, output bit term);
    logic [5:0] ifn;
    bit         wb, mem, st;
    q.delete();
    term = 1'b0;
    for (int k = 0; k < iw && k < TO; k++) add(1'b0, rb(), rb(), r6(), r6(), ov(1,0,0,2'b00,0,0,6'd0,0,0,0,0,0,0,0,0));
    if (iw >= TO) begin
      add_hold(ov(0,0,0,2'b00,0,0,6'd0,0,0,0,0,0,0,0,1));
      term = 1'b1;
      return;
    end
    add(1'b1, rb(), rb(), op, fn, ov(1,1,1,2'b00,0,0,6'd0,0,0,0,0,0,0,0,0));
    add(rb(), rb(), rb(), r6(), r6(), '0);
    wb = 1'b0; mem = 1'b0; st = 1'b0; ifn = 6'd0;
    case (op)
      6'b000001: return;
      6'b000010: begin add_hold(ov(0,0,0,2'b00,0,0,6'd0,0,0,0,0,0,1,0,0)); term = 1'b1; return; end
      6'b000000: begin add(rb(), rb(), rb(), r6(), r6(), ov(0,0,0,2'b00,0,0,fn,0,0,0,0,0,0,0,0)); wb = 1'b1; end
      6'b001000: begin ifn = 6'b100000; wb = 1'b1; end
      6'b001110: begin ifn = 6'b100010; wb = 1'b1; end
      6'b001100: begin ifn = 6'b100100; wb = 1'b1; end
      6'b001101: begin ifn = 6'b100101; wb = 1'b1; end
      6'b100011: begin ifn = 6'b100000; mem = 1'b1; wb = 1'b1; end
      6'b101011: begin ifn = 6'b100000; mem = 1'b1; st = 1'b1; end
      6'b010000: add(rb(), rb(), rb(), r6(), r6(), ov(0,0,1,2'b01,0,0,6'd0,0,0,0,0,0,0,0,0));
      6'b001001: add(rb(), rb(), rb(), r6(), r6(), ov(0,0,1,2'b10,0,0,6'd0,0,0,0,0,0,0,0,0));
      6'b010001: add(rb(), rb(), fl, r6(), r6(), ov(0,0,fl,2'b10,0,0,6'd0,0,0,0,0,0,0,0,0));
      6'b000011: add(rb(), rb(), rb(), r6(), r6(), ov(0,0,1,2'b10,0,0,6'd0,0,0,0,1,0,0,0,0));
      6'b000111: add(rb(), rb(), rb(), r6(), r6(), ov(0,0,1,2'b11,0,0,6'd0,0,0,0,0,1,0,0,0));
      default: begin add_hold(ov(0,0,0,2'b00,0,0,6'd0,0,0,0,0,0,0,1,0)); term = 1'b1; return; end
    endcase
    if (ifn != 6'd0) add(rb(), rb(), rb(), r6(), r6(), ov(0,0,0,2'b00,0,1,ifn,0,0,0,0,0,0,0,0));
    if (mem) begin
      for (int k = 0; k < dw && k < TO; k++) add(rb(), 1'b0, rb(), r6(), r6(), ov(0,0,0,2'b00,0,0,6'd0,1,st,0,0,0,0,0,0));
      if (dw >= TO) begin
        add_hold(ov(0,0,0,2'b00,0,0,6'd0,0,0,0,0,0,0,0,1));
        term = 1'b1;
        return;
      end
      add(rb(), 1'b1, rb(), r6(), r6(), ov(0,0,0,2'b00,0,0,6'd0,1,st,0,0,0,0,0,0));
    end
    if (wb) add(rb(), rb(), rb(), r6(), r6(), ov(0,0,0,2'b00,1,0,6'd0,0,0,!st && mem,0,0,0,0,0));
  endtask

  task automatic play(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      imem_ack = q[i].ia; dmem_ack = q[i].da; flag_in = q[i].fl;
      opcode_in = q[i].op; funct_in = q[i].fn;
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, i), act, q[i].exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; flag_in = 1'b1; opcode_in = r6(); funct_in = r6();
    @(negedge clk);
    chk("in_reset", act, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; imem_ack = rb(); dmem_ack = rb(); flag_in = rb();
    @(negedge clk);
    chk("first_after_reset", act, '0);
  endtask

  task automatic run(input string tag, input logic [5:0] op, fn, input int iw, dw, input logic fl);
    bit term;
    gen(op, fn, iw, dw, fl, term);
    play(tag, q.size());
    if (term) do_reset();
  endtask

  function automatic int rdelay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return $urandom_range(0, 2);
    if (r < 90) return $urandom_range(3, 6);
    if (r < 97) return TO - 1;
    return $urandom_range(TO, TO + 2);
  endfunction

  initial begin
    logic [5:0] legal [12];
    logic [5:0] op;
    bit         term;
    int         r;
    legal = '{6'b000000, 6'b001000, 6'b001110, 6'b001100, 6'b001101, 6'b100011,
              6'b101011, 6'b010000, 6'b001001, 6'b010001, 6'b000011, 6'b000111};
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; flag_in = 1'b0; opcode_in = '0; funct_in = '0;
    do_reset();

    run("addi",      6'b001000, r6(), 0, 0, 1'b0);
    run("lw_d3",     6'b100011, r6(), 0, 3, 1'b0);
    run("brfl_f0",   6'b010001, r6(), 0, 0, 1'b0);
    run("brfl_f1",   6'b010001, r6(), 0, 0, 1'b1);
    run("call",      6'b000011, r6(), 0, 0, 1'b0);
    run("ret",       6'b000111, r6(), 0, 0, 1'b0);
    run("r_type",    6'b000000, 6'b101010, 1, 0, 1'b0);
    run("sw",        6'b101011, r6(), 2, 1, 1'b0);
    run("nop",       6'b000001, r6(), 0, 0, 1'b0);
    run("subi",      6'b001110, r6(), 0, 0, 1'b0);
    run("andi",      6'b001100, r6(), 0, 0, 1'b0);
    run("ori",       6'b001101, r6(), 0, 0, 1'b0);
    run("jr",        6'b010000, r6(), 0, 0, 1'b0);
    run("jpc",       6'b001001, r6(), 0, 0, 1'b0);
    run("iack_15th", 6'b001000, r6(), TO - 1, 0, 1'b0);
    run("dack_15th", 6'b100011, r6(), 0, TO - 1, 1'b0);
    run("illegal",   6'b111111, r6(), 0, 0, 1'b0);
    run("halt",      6'b000010, r6(), 0, 0, 1'b0);
    run("itimeout",  6'b001000, r6(), TO, 0, 1'b0);
    run("dtimeout",  6'b101011, r6(), 0, TO + 3, 1'b0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) op = 6'b000010;
      else if (r < 8) begin
        op = r6();
        while (is_legal(op)) op = r6();
      end else if (r < 14) op = 6'b000001;
      else op = legal[$urandom_range(0, 11)];
      gen(op, r6(), rdelay(), rdelay(), rb(), term);
      if ($urandom_range(0, 29) == 0) begin
        play($sformatf("rnd%0d_abort", n), $urandom_range(1, q.size() - 1));
        do_reset();
      end else begin
        play($sformatf("rnd%0d_op%b", n, op), q.size());
        if (term) do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
